// File: rtl/sdram_refresh_sched.sv
// SDRAM init sequencer and refresh scheduler for the alt-RAM/ROM shadow.
// Owns the command bus except while the 68k access engine holds a grant.
module sdram_refresh_sched #(
  parameter int          INIT_WAIT    = 12800,
  parameter int          REF_INTERVAL = 499,
  parameter int          INIT_REFS    = 8,
  parameter int          TRP          = 2,
  parameter int          TRFC         = 5,
  parameter int          TMRD         = 2,
  parameter int          URGENT       = 4,
  parameter logic [12:0] MODE_WORD    = 13'h020
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ACC_REQ,
  output logic        ACC_GNT,
  output logic        READY,
  output logic        CMD_OWN,
  output logic        RAS,
  output logic        CAS,
  output logic        RAMWE,
  output logic [1:0]  BA,
  output logic [12:0] MA,
  output logic [3:0]  REF_DEBT
);

  localparam int WAIT_MAX = (TRP > TRFC) ? ((TRP > TMRD) ? TRP : TMRD)
                                         : ((TRFC > TMRD) ? TRFC : TMRD);
  localparam int WAIT_W  = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam int INIT_W  = $clog2(INIT_WAIT + 1);
  localparam int TIMER_W = $clog2(REF_INTERVAL + 1);
  localparam int IREF_W  = $clog2(INIT_REFS + 1);

  localparam logic [WAIT_W-1:0]  TRP_CNT    = WAIT_W'(TRP);
  localparam logic [WAIT_W-1:0]  TRFC_CNT   = WAIT_W'(TRFC);
  localparam logic [WAIT_W-1:0]  TMRD_CNT   = WAIT_W'(TMRD);
  localparam logic [INIT_W-1:0]  INIT_LAST  = INIT_W'(INIT_WAIT - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(REF_INTERVAL - 1);
  localparam logic [IREF_W-1:0]  IREF_LAST  = IREF_W'(INIT_REFS);
  localparam logic [3:0]         URGENT_LVL = 4'(URGENT);

  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_MRS = 3'b000;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_PRE,
    ST_IREF,
    ST_MRS,
    ST_IDLE,
    ST_GRANT,
    ST_REF
  } state_t;

  state_t               state;
  logic [2:0]           cmd_q;
  logic [INIT_W-1:0]    init_cnt;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [IREF_W-1:0]    iref_cnt;
  logic [TIMER_W-1:0]   ref_timer;
  logic                 tick;
  logic                 tick_live;
  logic                 ref_take;

  assign {RAS, CAS, RAMWE} = cmd_q;

  // Idle arbitration: urgent debt beats a request, a request beats ordinary debt.
  always_comb begin
    tick      = (ref_timer == TIMER_LAST);
    tick_live = tick && READY;
    ref_take  = (state == ST_IDLE) &&
                ((REF_DEBT >= URGENT_LVL) || (!ACC_REQ && (REF_DEBT != 4'd0)));
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      ref_timer <= '0;
    end else if (ref_timer == TIMER_LAST) begin
      ref_timer <= '0;
    end else begin
      ref_timer <= ref_timer + 1'b1;
    end
  end

  // ref_take only fires with nonzero debt, so the decrement cannot underflow.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      REF_DEBT <= 4'd0;
    end else if (tick_live && !ref_take) begin
      if (REF_DEBT != 4'd15) begin
        REF_DEBT <= REF_DEBT + 4'd1;
      end
    end else if (ref_take && !tick_live) begin
      REF_DEBT <= REF_DEBT - 4'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= ST_WAIT;
      cmd_q    <= CMD_NOP;
      BA       <= 2'b00;
      MA       <= 13'h0000;
      init_cnt <= '0;
      wait_cnt <= '0;
      iref_cnt <= '0;
      CMD_OWN  <= 1'b1;
      ACC_GNT  <= 1'b0;
      READY    <= 1'b0;
    end else begin
      cmd_q <= CMD_NOP;
      BA    <= 2'b00;
      MA    <= 13'h0000;
      case (state)
        ST_WAIT: begin
          if (init_cnt == INIT_LAST) begin
            cmd_q    <= CMD_PRE;
            MA       <= 13'h0400;
            wait_cnt <= TRP_CNT;
            state    <= ST_PRE;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        ST_PRE: begin
          if (wait_cnt == '0) begin
            cmd_q    <= CMD_REF;
            iref_cnt <= IREF_W'(1);
            wait_cnt <= TRFC_CNT;
            state    <= ST_IREF;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_IREF: begin
          if (wait_cnt == '0) begin
            if (iref_cnt == IREF_LAST) begin
              cmd_q    <= CMD_MRS;
              MA       <= MODE_WORD;
              wait_cnt <= TMRD_CNT;
              state    <= ST_MRS;
            end else begin
              cmd_q    <= CMD_REF;
              iref_cnt <= iref_cnt + 1'b1;
              wait_cnt <= TRFC_CNT;
            end
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_MRS: begin
          if (wait_cnt == '0) begin
            READY <= 1'b1;
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_IDLE: begin
          if (ref_take) begin
            cmd_q    <= CMD_REF;
            wait_cnt <= TRFC_CNT;
            state    <= ST_REF;
          end else if (ACC_REQ) begin
            ACC_GNT <= 1'b1;
            CMD_OWN <= 1'b0;
            state   <= ST_GRANT;
          end
        end
        // The engine closes its rows with auto-precharge, so release needs no PRECHARGE.
        ST_GRANT: begin
          if (!ACC_REQ) begin
            ACC_GNT <= 1'b0;
            CMD_OWN <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        ST_REF: begin
          if (wait_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_refresh_sched.sv
// Directed bench for sdram_refresh_sched: per-cycle expectations queued ahead
// of the clock and popped against the DUT outputs one cycle at a time.
module tb_sdram_refresh_sched;

  localparam logic [2:0] C_NOP = 3'b111;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_MRS = 3'b000;

  localparam int A_NONE = 0;
  localparam int A_PRE  = 1;
  localparam int A_MRS  = 2;
  localparam int A_RST  = 3;

  typedef struct {
    logic [2:0] cmd;
    logic       gnt;
    logic       own;
    logic       rdy;
    logic [3:0] debt;
    int         amode;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ACC_REQ;
  logic        ACC_GNT;
  logic        READY;
  logic        CMD_OWN;
  logic        RAS;
  logic        CAS;
  logic        RAMWE;
  logic [1:0]  BA;
  logic [12:0] MA;
  logic [3:0]  REF_DEBT;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  sdram_refresh_sched #(
    .INIT_WAIT   (10),
    .REF_INTERVAL(20),
    .INIT_REFS   (2),
    .TRP         (2),
    .TRFC        (3),
    .TMRD        (2),
    .URGENT      (2),
    .MODE_WORD   (13'h020)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .ACC_REQ (ACC_REQ),
    .ACC_GNT (ACC_GNT),
    .READY   (READY),
    .CMD_OWN (CMD_OWN),
    .RAS     (RAS),
    .CAS     (CAS),
    .RAMWE   (RAMWE),
    .BA      (BA),
    .MA      (MA),
    .REF_DEBT(REF_DEBT)
  );

  always #5 CLK = ~CLK;

  task automatic push_run(input int n, input logic [2:0] cmd, input logic gnt,
                          input logic own, input logic rdy, input logic [3:0] debt,
                          input int amode);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{cmd, gnt, own, rdy, debt, amode});
    end
  endtask

  task automatic applyStimulus(input logic rst_v, input logic req_v);
    RST     = rst_v;
    ACC_REQ = req_v;
  endtask

  task automatic checkOutput(input exp_t e);
    logic [2:0] cmd_obs;
    cmd_obs = {RAS, CAS, RAMWE};
    checks++;
    assert (cmd_obs === e.cmd) else begin
      errors++;
      $error("[TB] FAIL cmd @%0d: observed %b expected %b", cyc, cmd_obs, e.cmd);
    end
    checks++;
    assert (ACC_GNT === e.gnt) else begin
      errors++;
      $error("[TB] FAIL acc_gnt @%0d: observed %b expected %b", cyc, ACC_GNT, e.gnt);
    end
    checks++;
    assert (CMD_OWN === e.own) else begin
      errors++;
      $error("[TB] FAIL cmd_own @%0d: observed %b expected %b", cyc, CMD_OWN, e.own);
    end
    checks++;
    assert (READY === e.rdy) else begin
      errors++;
      $error("[TB] FAIL ready @%0d: observed %b expected %b", cyc, READY, e.rdy);
    end
    checks++;
    assert (REF_DEBT === e.debt) else begin
      errors++;
      $error("[TB] FAIL ref_debt @%0d: observed %0d expected %0d", cyc, REF_DEBT, e.debt);
    end
    if (e.amode == A_PRE) begin
      checks++;
      assert (MA[10] === 1'b1) else begin
        errors++;
        $error("[TB] FAIL pre_ma10 @%0d: observed %b expected 1", cyc, MA[10]);
      end
    end else if (e.amode == A_MRS) begin
      checks++;
      assert (MA === 13'h020 && BA === 2'b00) else begin
        errors++;
        $error("[TB] FAIL mrs_addr @%0d: observed MA=%h BA=%b expected MA=020 BA=00",
               cyc, MA, BA);
      end
    end else if (e.amode == A_RST) begin
      checks++;
      assert (MA === 13'h000 && BA === 2'b00) else begin
        errors++;
        $error("[TB] FAIL reset_addr @%0d: observed MA=%h BA=%b expected MA=000 BA=00",
               cyc, MA, BA);
      end
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic run_queue();
    exp_t e;
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      checkOutput(e);
    end
  endtask

  // Cycles 1..24 after reset release: wait, PRECHARGE, two REFRESHes, MRS, READY.
  task automatic push_init_seq();
    push_run(9, C_NOP, 1'b0, 1'b1, 1'b0, 4'd0, A_NONE);
    push_run(1, C_PRE, 1'b0, 1'b1, 1'b0, 4'd0, A_PRE);
    push_run(2, C_NOP, 1'b0, 1'b1, 1'b0, 4'd0, A_NONE);
    push_run(1, C_REF, 1'b0, 1'b1, 1'b0, 4'd0, A_NONE);
    push_run(3, C_NOP, 1'b0, 1'b1, 1'b0, 4'd0, A_NONE);
    push_run(1, C_REF, 1'b0, 1'b1, 1'b0, 4'd0, A_NONE);
    push_run(3, C_NOP, 1'b0, 1'b1, 1'b0, 4'd0, A_NONE);
    push_run(1, C_MRS, 1'b0, 1'b1, 1'b0, 4'd0, A_MRS);
    push_run(2, C_NOP, 1'b0, 1'b1, 1'b0, 4'd0, A_NONE);
    push_run(1, C_NOP, 1'b0, 1'b1, 1'b1, 4'd0, A_NONE);
  endtask

  initial begin
    exp_t e;
    int   d;
    applyStimulus(1'b0, 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    applyStimulus(1'b1, 1'b0);
    cyc = 0;
    push_run(1, C_NOP, 1'b0, 1'b1, 1'b0, 4'd0, A_RST);
    e = exp_q.pop_front();
    checkOutput(e);

    push_init_seq();
    push_run(2, C_NOP, 1'b0, 1'b1, 1'b1, 4'd0, A_NONE);
    run_queue();

    // Plain grant: one-cycle latency, six cycles held, one-cycle release.
    applyStimulus(1'b1, 1'b1);
    push_run(6, C_NOP, 1'b1, 1'b0, 1'b1, 4'd0, A_NONE);
    run_queue();
    applyStimulus(1'b1, 1'b0);
    push_run(7, C_NOP, 1'b0, 1'b1, 1'b1, 4'd0, A_NONE);
    push_run(1, C_NOP, 1'b0, 1'b1, 1'b1, 4'd1, A_NONE);
    push_run(1, C_REF, 1'b0, 1'b1, 1'b1, 4'd0, A_NONE);
    push_run(18, C_NOP, 1'b0, 1'b1, 1'b1, 4'd0, A_NONE);
    push_run(1, C_NOP, 1'b0, 1'b1, 1'b1, 4'd1, A_NONE);
    push_run(1, C_REF, 1'b0, 1'b1, 1'b1, 4'd0, A_NONE);
    run_queue();

    // Request raised while a refresh issues: grant after 1+TRFC+1 cycles.
    applyStimulus(1'b1, 1'b1);
    push_run(4, C_NOP, 1'b0, 1'b1, 1'b1, 4'd0, A_NONE);
    push_run(14, C_NOP, 1'b1, 1'b0, 1'b1, 4'd0, A_NONE);
    push_run(19, C_NOP, 1'b1, 1'b0, 1'b1, 4'd1, A_NONE);
    run_queue();

    // Release so the debt-1 refresh lands on the same edge as a tick.
    applyStimulus(1'b1, 1'b0);
    push_run(1, C_NOP, 1'b0, 1'b1, 1'b1, 4'd1, A_NONE);
    push_run(1, C_REF, 1'b0, 1'b1, 1'b1, 4'd1, A_NONE);
    push_run(4, C_NOP, 1'b0, 1'b1, 1'b1, 4'd1, A_NONE);
    push_run(1, C_REF, 1'b0, 1'b1, 1'b1, 4'd0, A_NONE);
    run_queue();

    applyStimulus(1'b1, 1'b1);
    push_run(4, C_NOP, 1'b0, 1'b1, 1'b1, 4'd0, A_NONE);
    push_run(10, C_NOP, 1'b1, 1'b0, 1'b1, 4'd0, A_NONE);
    push_run(20, C_NOP, 1'b1, 1'b0, 1'b1, 4'd1, A_NONE);
    push_run(19, C_NOP, 1'b1, 1'b0, 1'b1, 4'd2, A_NONE);
    run_queue();
    applyStimulus(1'b1, 1'b0);
    push_run(1, C_NOP, 1'b0, 1'b1, 1'b1, 4'd2, A_NONE);
    run_queue();

    // Urgent debt: the pending request waits behind two refreshes.
    applyStimulus(1'b1, 1'b1);
    push_run(1, C_REF, 1'b0, 1'b1, 1'b1, 4'd2, A_NONE);
    push_run(4, C_NOP, 1'b0, 1'b1, 1'b1, 4'd2, A_NONE);
    push_run(1, C_REF, 1'b0, 1'b1, 1'b1, 4'd1, A_NONE);
    push_run(4, C_NOP, 1'b0, 1'b1, 1'b1, 4'd1, A_NONE);
    for (int c = 170; c <= 565; c++) begin
      d = (c >= 180) ? ((c - 180) / 20 + 2) : 1;
      if (d > 15) d = 15;
      push_run(1, C_NOP, 1'b1, 1'b0, 1'b1, 4'(d), A_NONE);
    end
    run_queue();

    // Reset pulse mid-grant, request kept high through the repeated init.
    applyStimulus(1'b0, 1'b1);
    push_run(1, C_NOP, 1'b0, 1'b1, 1'b0, 4'd0, A_RST);
    run_queue();
    applyStimulus(1'b1, 1'b1);
    cyc = 0;
    push_init_seq();
    push_run(2, C_NOP, 1'b1, 1'b0, 1'b1, 4'd0, A_NONE);
    run_queue();
    applyStimulus(1'b1, 1'b0);
    push_run(1, C_NOP, 1'b0, 1'b1, 1'b1, 4'd0, A_NONE);
    run_queue();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
